// File: rtl/miss_repair_engine_pkg.sv
// Shared types for the MSHR repair responder: ROB sizing, FSM state encoding and the
// captured repair request record.
package miss_repair_engine_pkg;

   localparam int ROB_ENTRIES = 32;
   localparam int ROB_IDX_W   = $clog2(ROB_ENTRIES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_RESP = 3'd2,
      WB        = 3'd3,
      DONE      = 3'd4
   } repair_state_e;

   typedef struct packed {
      logic [31:0]          addr;
      logic [31:0]          data;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic                 is_store;
   } repair_req_t;

   // Bundle the MSHR request fields into the capture record.
   function automatic repair_req_t pack_req(input logic [31:0]          addr,
                                            input logic [31:0]          data,
                                            input logic [ROB_IDX_W-1:0] rob_idx,
                                            input logic                 is_store);
      repair_req_t r;
      r.addr     = addr;
      r.data     = data;
      r.rob_idx  = rob_idx;
      r.is_store = is_store;
      return r;
   endfunction

endpackage

// File: rtl/miss_repair_engine.sv
// Responder for the MSHR repair handshake: one word load/store per repair, D$ fill and ROB writeback for loads.
// Latency: ack combinational in IDLE; memory request the next cycle; complete one cycle after store response or load writeback.
// Backpressure: memory request held until mem_req_ready_i, writeback held until ld_wb_ready_i; no ack while busy.
module miss_repair_engine
   import miss_repair_engine_pkg::*;
#(
   parameter int RESP_TIMEOUT = 64,
   parameter int MAX_RETRIES  = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   // MSHR side
   input  logic                 repair_req_i,
   input  logic [31:0]          repair_addr_i,
   input  logic [31:0]          repair_data_i,
   input  logic [ROB_IDX_W-1:0] repair_rob_idx_i,
   input  logic                 repair_is_store_i,
   output logic                 repair_ack_o,
   output logic                 repair_complete_o,
   // memory side
   output logic                 mem_req_valid_o,
   input  logic                 mem_req_ready_i,
   output logic                 mem_req_we_o,
   output logic [31:0]          mem_req_addr_o,
   output logic [31:0]          mem_req_wdata_o,
   input  logic                 mem_resp_valid_i,
   input  logic [31:0]          mem_resp_rdata_i,
   // D$ fill
   output logic                 fill_en_o,
   output logic [31:0]          fill_addr_o,
   output logic [31:0]          fill_data_o,
   // ROB / CDB load writeback
   output logic                 ld_wb_valid_o,
   input  logic                 ld_wb_ready_i,
   output logic [31:0]          ld_wb_data_o,
   output logic [ROB_IDX_W-1:0] ld_wb_rob_idx_o,
   output logic                 ld_wb_err_o,
   output logic                 err_o
);

   localparam int TMO_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
   localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

   repair_state_e    state_q;
   repair_req_t      cap_q;
   logic [31:0]      rdata_q;
   logic [TMO_W-1:0] tmo_q;
   logic [RTY_W-1:0] retry_q;

   // Ack is only offered from IDLE and is gated by reset so a request seen during reset is never taken.
   assign repair_ack_o = (state_q == IDLE) && repair_req_i && rst_ni;

   // Request, fill and writeback fields come straight from the capture/read-data registers, so they
   // are stable for as long as the corresponding valid is held.
   assign mem_req_we_o    = cap_q.is_store;
   assign mem_req_addr_o  = cap_q.addr;
   assign mem_req_wdata_o = cap_q.data;
   assign fill_addr_o     = cap_q.addr;
   assign fill_data_o     = rdata_q;
   assign ld_wb_data_o    = rdata_q;
   assign ld_wb_rob_idx_o = cap_q.rob_idx;

   // Repair FSM with registered strobes; each branch sets the outputs for the state it moves into.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q           <= IDLE;
         cap_q             <= '0;
         rdata_q           <= '0;
         tmo_q             <= '0;
         retry_q           <= '0;
         mem_req_valid_o   <= 1'b0;
         fill_en_o         <= 1'b0;
         ld_wb_valid_o     <= 1'b0;
         ld_wb_err_o       <= 1'b0;
         repair_complete_o <= 1'b0;
         err_o             <= 1'b0;
      end else begin
         // single-cycle strobes
         fill_en_o         <= 1'b0;
         repair_complete_o <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (repair_ack_o) begin
                  cap_q           <= pack_req(repair_addr_i, repair_data_i,
                                              repair_rob_idx_i, repair_is_store_i);
                  tmo_q           <= '0;
                  retry_q         <= '0;
                  mem_req_valid_o <= 1'b1;
                  state_q         <= ISSUE;
               end
            end

            ISSUE: begin
               if (mem_req_ready_i) begin
                  mem_req_valid_o <= 1'b0;
                  tmo_q           <= '0;
                  state_q         <= WAIT_RESP;
               end
            end

            WAIT_RESP: begin
               // A response takes priority over an expiry in the same cycle.
               if (mem_resp_valid_i) begin
                  if (cap_q.is_store) begin
                     repair_complete_o <= 1'b1;
                     state_q           <= DONE;
                  end else begin
                     rdata_q       <= mem_resp_rdata_i;
                     fill_en_o     <= 1'b1;
                     ld_wb_valid_o <= 1'b1;
                     ld_wb_err_o   <= 1'b0;
                     state_q       <= WB;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  if (retry_q < RTY_MAX) begin
                     retry_q         <= retry_q + 1'b1;
                     mem_req_valid_o <= 1'b1;
                     state_q         <= ISSUE;
                  end else begin
                     // Retries exhausted: retire the miss with error; a load still owes the ROB a result.
                     err_o <= 1'b1;
                     if (cap_q.is_store) begin
                        repair_complete_o <= 1'b1;
                        state_q           <= DONE;
                     end else begin
                        rdata_q       <= '0;
                        ld_wb_valid_o <= 1'b1;
                        ld_wb_err_o   <= 1'b1;
                        state_q       <= WB;
                     end
                  end
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end

            WB: begin
               if (ld_wb_ready_i) begin
                  ld_wb_valid_o     <= 1'b0;
                  ld_wb_err_o       <= 1'b0;
                  repair_complete_o <= 1'b1;
                  state_q           <= DONE;
               end
            end

            DONE: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_miss_repair_engine.sv
// Bench for miss_repair_engine: directed scenarios plus randomized repairs, each scored against
// an outcome model (issue count, error, returned data) derived from when memory answers.
module tb_miss_repair_engine;
   import miss_repair_engine_pkg::*;

   localparam int TMO  = 8;
   localparam int MAXR = 2;

   logic                 clk = 1'b0;
   logic                 rst_ni;
   logic                 repair_req_i;
   logic [31:0]          repair_addr_i;
   logic [31:0]          repair_data_i;
   logic [ROB_IDX_W-1:0] repair_rob_idx_i;
   logic                 repair_is_store_i;
   logic                 repair_ack_o;
   logic                 repair_complete_o;
   logic                 mem_req_valid_o;
   logic                 mem_req_ready_i;
   logic                 mem_req_we_o;
   logic [31:0]          mem_req_addr_o;
   logic [31:0]          mem_req_wdata_o;
   logic                 mem_resp_valid_i;
   logic [31:0]          mem_resp_rdata_i;
   logic                 fill_en_o;
   logic [31:0]          fill_addr_o;
   logic [31:0]          fill_data_o;
   logic                 ld_wb_valid_o;
   logic                 ld_wb_ready_i;
   logic [31:0]          ld_wb_data_o;
   logic [ROB_IDX_W-1:0] ld_wb_rob_idx_o;
   logic                 ld_wb_err_o;
   logic                 err_o;

   miss_repair_engine #(.RESP_TIMEOUT(TMO), .MAX_RETRIES(MAXR)) dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .repair_req_i      (repair_req_i),
      .repair_addr_i     (repair_addr_i),
      .repair_data_i     (repair_data_i),
      .repair_rob_idx_i  (repair_rob_idx_i),
      .repair_is_store_i (repair_is_store_i),
      .repair_ack_o      (repair_ack_o),
      .repair_complete_o (repair_complete_o),
      .mem_req_valid_o   (mem_req_valid_o),
      .mem_req_ready_i   (mem_req_ready_i),
      .mem_req_we_o      (mem_req_we_o),
      .mem_req_addr_o    (mem_req_addr_o),
      .mem_req_wdata_o   (mem_req_wdata_o),
      .mem_resp_valid_i  (mem_resp_valid_i),
      .mem_resp_rdata_i  (mem_resp_rdata_i),
      .fill_en_o         (fill_en_o),
      .fill_addr_o       (fill_addr_o),
      .fill_data_o       (fill_data_o),
      .ld_wb_valid_o     (ld_wb_valid_o),
      .ld_wb_ready_i     (ld_wb_ready_i),
      .ld_wb_data_o      (ld_wb_data_o),
      .ld_wb_rob_idx_o   (ld_wb_rob_idx_o),
      .ld_wb_err_o       (ld_wb_err_o),
      .err_o             (err_o)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   resp_k [0:MAXR];   // WAIT cycle index at which memory answers each attempt (>= TMO: never)
   logic err_sticky = 1'b0; // model of err_o

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs are driven and outputs sampled at the falling edge
   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   function automatic logic any_out();
      return |{repair_ack_o, repair_complete_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o,
               mem_req_wdata_o, fill_en_o, fill_addr_o, fill_data_o, ld_wb_valid_o, ld_wb_data_o,
               ld_wb_rob_idx_o, ld_wb_err_o, err_o};
   endfunction

   // One repair, with a memory that stalls ready for rdy_wait cycles and answers per resp_k[].
   task automatic run_txn(input logic st, input logic [31:0] a, input logic [31:0] d,
                          input logic [ROB_IDX_W-1:0] rob, input int rdy_wait, input int wb_wait,
                          input logic [31:0] rd, input logic hold);
      int          n_issue, issues, hold_cnt, k, att, fills, wb_cnt, bound;
      int          resp_cyc, last_evt, done_cyc, prev_issue;
      logic        exp_err, in_issue, in_wait, done_seen;
      logic        fld_bad, ack_bad, fill_bad, wb_bad, space_bad;
      logic [31:0] exp_rd;

      // outcome model: the first attempt answered inside its window wins
      exp_err = 1'b1;
      n_issue = MAXR + 1;
      for (int i = MAXR; i >= 0; i--) begin
         if (resp_k[i] < TMO) begin
            n_issue = i + 1;
            exp_err = 1'b0;
         end
      end
      exp_rd = exp_err ? 32'h0 : rd;
      if (exp_err) err_sticky = 1'b1;

      repair_req_i      = 1'b1;
      repair_addr_i     = a;
      repair_data_i     = d;
      repair_rob_idx_i  = rob;
      repair_is_store_i = st;
      #1;
      chk("ack_idle", 64'(repair_ack_o), 64'(1));
      step();
      repair_req_i = hold;

      issues = 0; hold_cnt = 0; k = 0; att = -1; fills = 0; wb_cnt = 0; bound = 0;
      resp_cyc = -100; last_evt = -100; done_cyc = -200; prev_issue = 0;
      in_issue = 0; in_wait = 0; done_seen = 0;
      fld_bad = 0; ack_bad = 0; fill_bad = 0; wb_bad = 0; space_bad = 0;

      while (!done_seen && bound < 300) begin
         bound++;
         mem_req_ready_i  = 1'b0;
         mem_resp_valid_i = 1'b0;
         mem_resp_rdata_i = $urandom;
         ld_wb_ready_i    = 1'b0;
         if (repair_ack_o) ack_bad = 1;
         if (mem_req_valid_o) begin
            if (!in_issue) begin
               in_issue = 1; in_wait = 0; hold_cnt = 0; att++; issues++;
               if (issues > 1 && (cyc - prev_issue) != rdy_wait + 1 + TMO) space_bad = 1;
               prev_issue = cyc;
            end
            if (mem_req_we_o !== st || mem_req_addr_o !== a || (st && mem_req_wdata_o !== d))
               fld_bad = 1;
            if (hold_cnt == rdy_wait) begin
               mem_req_ready_i = 1'b1;
               in_issue = 0; in_wait = 1; k = -1;
            end else begin
               hold_cnt++;
            end
         end else if (in_issue) begin
            fld_bad = 1;  // request withdrawn before acceptance
         end else if (in_wait) begin
            k++;
            if (att >= 0 && att <= MAXR && k == resp_k[att] && k < TMO) begin
               mem_resp_valid_i = 1'b1;
               mem_resp_rdata_i = rd;
               resp_cyc = cyc;
               in_wait = 0;
               if (st) last_evt = cyc;
            end else if (k == TMO - 1) begin
               in_wait = 0;
               last_evt = cyc;
            end
         end
         if (fill_en_o) begin
            fills++;
            if (fill_addr_o !== a || fill_data_o !== rd || cyc != resp_cyc + 1) fill_bad = 1;
         end
         if (ld_wb_valid_o) begin
            wb_cnt++;
            last_evt = cyc;
            if (ld_wb_data_o !== exp_rd || ld_wb_rob_idx_o !== rob || ld_wb_err_o !== exp_err)
               wb_bad = 1;
            if (wb_cnt == wb_wait + 1) ld_wb_ready_i = 1'b1;
         end
         if (repair_complete_o) begin
            done_seen = 1;
            done_cyc  = cyc;
         end
         if (!done_seen) step();
      end

      chk("complete_seen", 64'(done_seen), 64'(1));
      chk("issue_count", 64'(issues), 64'(n_issue));
      chk("reissue_spacing", 64'(space_bad), 64'(0));
      chk("mem_fields", 64'(fld_bad), 64'(0));
      chk("fill_count", 64'(fills), 64'((st || exp_err) ? 0 : 1));
      chk("fill_fields", 64'(fill_bad), 64'(0));
      chk("wb_cycles", 64'(wb_cnt), 64'(st ? 0 : wb_wait + 1));
      chk("wb_fields", 64'(wb_bad), 64'(0));
      chk("complete_latency", 64'(done_cyc), 64'(last_evt + 1));
      chk("no_ack_busy", 64'(ack_bad), 64'(0));
      chk("err_sticky", 64'(err_o), 64'(err_sticky));
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b0;
      ld_wb_ready_i    = 1'b0;
      step();
      chk("complete_pulse", 64'(repair_complete_o), 64'(0));
   endtask

   initial begin
      logic bad;
      rst_ni            = 1'b0;
      repair_req_i      = 1'b1;
      repair_addr_i     = 32'h0;
      repair_data_i     = 32'h0;
      repair_rob_idx_i  = '0;
      repair_is_store_i = 1'b0;
      mem_req_ready_i   = 1'b0;
      mem_resp_valid_i  = 1'b0;
      mem_resp_rdata_i  = 32'h0;
      ld_wb_ready_i     = 1'b0;
      repeat (3) step();
      #1;
      chk("rst_no_ack", 64'(repair_ack_o), 64'(0));
      chk("rst_outputs", 64'(any_out()), 64'(0));
      repair_req_i = 1'b0;
      rst_ni = 1'b1;
      step();

      // load with ready stall 3, response on 3rd wait cycle, writeback ready after 2 cycles
      resp_k = '{2, 99, 99};
      run_txn(1'b0, 32'h0000_1000, 32'h0, ROB_IDX_W'(5), 3, 2, 32'hDEAD_BEEF, 1'b0);

      // store: response on first wait cycle
      resp_k = '{0, 99, 99};
      run_txn(1'b1, 32'h0000_2004, 32'h1234_5678, ROB_IDX_W'(9), 0, 0, 32'h0, 1'b0);

      // response coincides with expiry: no retry (load then store)
      resp_k = '{TMO - 1, 99, 99};
      run_txn(1'b0, 32'h0000_4440, 32'h0, ROB_IDX_W'(3), 1, 0, 32'hCAFE_F00D, 1'b0);
      run_txn(1'b1, 32'h0000_4444, 32'hA5A5_5A5A, ROB_IDX_W'(4), 0, 0, 32'h0, 1'b0);

      // back-to-back with request held high throughout
      resp_k = '{1, 99, 99};
      run_txn(1'b0, 32'h0000_5000, 32'h0, ROB_IDX_W'(7), 0, 1, 32'h1111_2222, 1'b1);
      run_txn(1'b1, 32'h0000_5004, 32'h3333_4444, ROB_IDX_W'(8), 0, 0, 32'h0, 1'b0);

      // no response at all: two re-issues then error writeback
      resp_k = '{99, 99, 99};
      run_txn(1'b0, 32'h0000_6000, 32'h0, ROB_IDX_W'(12), 0, 0, 32'h7777_7777, 1'b0);

      // reset while waiting for a response; the late response must be dropped
      repair_req_i      = 1'b1;
      repair_addr_i     = 32'h0000_3000;
      repair_is_store_i = 1'b0;
      repair_rob_idx_i  = ROB_IDX_W'(2);
      step();
      repair_req_i = 1'b0;
      chk("rst_mid_issue", 64'(mem_req_valid_o), 64'(1));
      mem_req_ready_i = 1'b1;
      step();
      mem_req_ready_i = 1'b0;
      step();
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      err_sticky = 1'b0;
      chk("rst_mid_outputs", 64'(any_out()), 64'(0));
      step();
      mem_resp_valid_i = 1'b1;
      mem_resp_rdata_i = 32'hBAD0_BAD0;
      step();
      mem_resp_valid_i = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (fill_en_o || ld_wb_valid_o || repair_complete_o || mem_req_valid_o) bad = 1'b1;
         step();
      end
      chk("late_resp_dropped", 64'(bad), 64'(0));

      // randomized repairs
      for (int n = 0; n < 14; n++) begin
         for (int i = 0; i <= MAXR; i++) resp_k[i] = $urandom_range(0, TMO + TMO / 2);
         run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                 ROB_IDX_W'($urandom_range(0, ROB_ENTRIES - 1)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
      end
      repair_req_i = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
